// File: rtl/vga_tile_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_tile_capture_if
// Purpose  : Bundles the VGA receive stream (pixel enable, syncs, RGB) and
//            the tile read port of vga_tile_capture.
// Ports    : master drives pix_ce/hsync/vsync/vga_r/vga_g/vga_b/rd_col/rd_row
//            and receives rd_code; slave is the capture block.
// Revision : 1.0  initial release
// ============================================================================
interface vga_tile_capture_if;
  logic       pix_ce;
  logic       hsync;
  logic       vsync;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;
  logic [3:0] rd_col;
  logic [2:0] rd_row;
  logic [2:0] rd_code;

  modport master (
    output pix_ce, hsync, vsync, vga_r, vga_g, vga_b, rd_col, rd_row,
    input  rd_code
  );

  modport slave (
    input  pix_ce, hsync, vsync, vga_r, vga_g, vga_b, rd_col, rd_row,
    output rd_code
  );
endinterface
`default_nettype wire

// File: rtl/vga_tile_capture.sv
`default_nettype none
// ============================================================================
// Module   : vga_tile_capture
// Purpose  : Receive-side VGA checker. Tracks x/y from the sync edges,
//            verifies line and frame length, samples the centre pixel of
//            each tile, decodes it to a 3-bit cell code and builds a 10x8
//            board image in a double-buffered store.
// Ports    : clk, rst        clock, synchronous active-high reset
//            bus (slave)     VGA stream in, tile read port (1-cycle latency)
//            frame_done      1-clk pulse when a clean frame swapped in
//            locked          LOCK_FRM consecutive clean frames seen
//            sync_err        1-clk pulse on a timing violation
//            color_err       sticky undecodable sample, cleared by frame_done
//            frame_cnt       clean frames captured (wrapping)
// Revision : 1.0  initial release
// ============================================================================
module vga_tile_capture #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACT0   = 144,
  parameter int V_ACT0   = 35,
  parameter int TILE_W   = 64,
  parameter int TILE_H   = 60,
  parameter int PIX_DLY  = 1,
  parameter int LOCK_FRM = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  vga_tile_capture_if.slave  bus,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_err,
  output logic               color_err,
  output logic [15:0]        frame_cnt
);

  localparam int N_COL  = 10;
  localparam int N_ROW  = 8;
  localparam int N_TILE = N_COL * N_ROW;
  localparam int XW     = $clog2(H_TOTAL + 1);
  localparam int YW     = $clog2(V_TOTAL + 1);
  localparam int LW     = $clog2(LOCK_FRM + 1);

  typedef enum logic [0:0] {
    ST_SEEK    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_prev_hs;
  logic            r_prev_vs;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_rd_bank;
  logic [2:0]      r_mem [0:1][0:N_TILE-1];
  logic [LW-1:0]   r_lock_cnt;
  logic            r_frame_done;
  logic            r_sync_err;
  logic            r_color_err;
  logic [15:0]     r_frame_cnt;
  logic [2:0]      r_rd_code;

  logic            w_hs_fall;
  logic            w_vs_fall;
  logic [XW-1:0]   w_x_cur;
  logic [YW-1:0]   w_y_cur;
  logic            w_line_err;
  logic            w_frame_ok;
  logic            w_frame_bad;
  logic            w_col_hit;
  logic            w_row_hit;
  logic [3:0]      w_col;
  logic [2:0]      w_row;
  logic [2:0]      w_code;
  logic            w_sample;
  logic [6:0]      w_wr_idx;
  logic [6:0]      w_rd_idx;
  logic            w_rd_sel;

  // Edges only count on pixel-enable samples.
  assign w_hs_fall = bus.pix_ce & r_prev_hs & ~bus.hsync;
  assign w_vs_fall = bus.pix_ce & r_prev_vs & ~bus.vsync;

  // Coordinates of the pixel being presented right now.
  assign w_x_cur = w_hs_fall ? '0 : r_x + 1'b1;
  assign w_y_cur = w_vs_fall ? '0 : (w_hs_fall ? r_y + 1'b1 : r_y);

  // Tile-centre hit detection; RGB lags the syncs by PIX_DLY pixels.
  always_comb begin
    w_col_hit = 1'b0;
    w_col     = '0;
    for (int c = 0; c < N_COL; c++) begin
      if (w_x_cur == XW'(H_ACT0 + TILE_W*c + TILE_W/2 + PIX_DLY)) begin
        w_col_hit = 1'b1;
        w_col     = 4'(c);
      end
    end
    w_row_hit = 1'b0;
    w_row     = '0;
    for (int r = 0; r < N_ROW; r++) begin
      if (w_y_cur == YW'(V_ACT0 + TILE_H*r + TILE_H/2)) begin
        w_row_hit = 1'b1;
        w_row     = 3'(r);
      end
    end
  end

  // Colour to cell code; 7 marks an undecodable sample.
  always_comb begin
    case ({bus.vga_r, bus.vga_g, bus.vga_b})
      8'b000_000_00: w_code = 3'd0;
      8'b000_000_01: w_code = 3'd1;
      8'b000_001_00: w_code = 3'd2;
      8'b000_001_01: w_code = 3'd3;
      8'b001_000_00: w_code = 3'd4;
      default:       w_code = 3'd7;
    endcase
  end

  // Next state and per-pixel timing verdicts.
  always_comb begin
    w_state_nxt = r_state;
    w_line_err  = 1'b0;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      ST_SEEK: begin
        if (w_vs_fall) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (bus.pix_ce) begin
          // A line is good only when hsync falls exactly after x = H_TOTAL-1:
          // an early fall or a missing fall are both violations.
          if (w_hs_fall != (r_x == XW'(H_TOTAL - 1))) begin
            w_line_err  = 1'b1;
            w_state_nxt = ST_SEEK;
          end else if (w_vs_fall) begin
            if (r_y == YW'(V_TOTAL - 1)) w_frame_ok  = 1'b1;
            else                         w_frame_bad = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_SEEK;
    endcase
  end

  assign w_sample = (r_state == ST_CAPTURE) & bus.pix_ce & ~w_line_err &
                    w_col_hit & w_row_hit;
  assign w_wr_idx = 7'(w_row) * 7'(N_COL) + 7'(w_col);
  assign w_rd_idx = 7'(bus.rd_row) * 7'(N_COL) + 7'(bus.rd_col);
  // A read coinciding with a swap already sees the newly completed bank.
  assign w_rd_sel = w_frame_ok ? ~r_rd_bank : r_rd_bank;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_SEEK;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Previous syncs start low so a fresh high-to-low edge is required.
      r_prev_hs    <= 1'b0;
      r_prev_vs    <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_rd_bank    <= 1'b0;
      r_lock_cnt   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_color_err  <= 1'b0;
      r_frame_cnt  <= '0;
      r_rd_code    <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_TILE; i++) begin
          r_mem[b][i] <= 3'd7;
        end
      end
    end else begin
      r_frame_done <= w_frame_ok;
      r_sync_err   <= w_line_err | w_frame_bad;

      if (bus.pix_ce) begin
        r_prev_hs <= bus.hsync;
        r_prev_vs <= bus.vsync;
        r_x       <= w_x_cur;
        r_y       <= w_y_cur;
      end

      if (w_sample) r_mem[~r_rd_bank][w_wr_idx] <= w_code;

      if (w_frame_ok) begin
        r_rd_bank   <= ~r_rd_bank;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (r_lock_cnt != LW'(LOCK_FRM)) r_lock_cnt <= r_lock_cnt + 1'b1;
      end else if (w_line_err | w_frame_bad) begin
        r_lock_cnt <= '0;
      end

      // Setting wins over the clear from a completing frame.
      if (w_sample && (w_code == 3'd7)) r_color_err <= 1'b1;
      else if (w_frame_ok)              r_color_err <= 1'b0;

      if (bus.rd_col >= 4'(N_COL)) r_rd_code <= 3'd7;
      else                         r_rd_code <= r_mem[w_rd_sel][w_rd_idx];
    end
  end

  assign frame_done  = r_frame_done;
  assign sync_err    = r_sync_err;
  assign color_err   = r_color_err;
  assign frame_cnt   = r_frame_cnt;
  assign locked      = (r_lock_cnt == LW'(LOCK_FRM));
  assign bus.rd_code = r_rd_code;

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_tile_capture
// Purpose  : Self-checking bench for vga_tile_capture using a reduced VGA
//            geometry. Generates frames from a board image, queues expected
//            frame results and tile reads, and compares them as the DUT
//            reports frame_done and returns read data.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_tile_capture;

  localparam int H_TOTAL  = 50;
  localparam int V_TOTAL  = 21;
  localparam int H_ACT0   = 6;
  localparam int V_ACT0   = 3;
  localparam int TILE_W   = 4;
  localparam int TILE_H   = 2;
  localparam int PIX_DLY  = 1;
  localparam int LOCK_FRM = 2;
  localparam int HS_W     = 4;
  localparam int VS_W     = 1;

  typedef struct packed {
    logic [15:0]  cnt;
    logic         lock;
    logic [239:0] img;
  } frm_t;

  typedef struct packed {
    logic [3:0] col;
    logic [2:0] row;
    logic [2:0] code;
  } rd_t;

  logic        clk;
  logic        rst;
  logic        frame_done;
  logic        locked;
  logic        sync_err;
  logic        color_err;
  logic [15:0] frame_cnt;

  vga_tile_capture_if bus ();

  vga_tile_capture #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .H_ACT0   (H_ACT0),
    .V_ACT0   (V_ACT0),
    .TILE_W   (TILE_W),
    .TILE_H   (TILE_H),
    .PIX_DLY  (PIX_DLY),
    .LOCK_FRM (LOCK_FRM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err),
    .color_err  (color_err),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cnt_m    = 0;
  int   lock_m   = 0;
  int   sync_cnt = 0;
  int   done_cnt = 0;
  frm_t fq [$];
  rd_t  rq [$];
  logic [2:0] img [80];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic logic [7:0] code_rgb(input logic [2:0] c);
    case (c)
      3'd0:    return 8'b000_000_00;
      3'd1:    return 8'b000_000_01;
      3'd2:    return 8'b000_001_00;
      3'd3:    return 8'b000_001_01;
      3'd4:    return 8'b001_000_00;
      default: return 8'b111_111_11;
    endcase
  endfunction

  function automatic logic [7:0] pix_rgb(input int px, input int y);
    if (px >= H_ACT0 && px < H_ACT0 + 10*TILE_W && y >= V_ACT0 && y < V_ACT0 + 8*TILE_H)
      return code_rgb(img[((y - V_ACT0) / TILE_H) * 10 + (px - H_ACT0) / TILE_W]);
    return 8'h00;
  endfunction

  function automatic logic [239:0] pack_img();
    logic [239:0] v;
    v = '0;
    for (int i = 0; i < 80; i++) v[i*3 +: 3] = img[i];
    return v;
  endfunction

  task automatic set_board0();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++)
        img[r*10 + c] = (r == 0 || r == 7 || c == 0 || c == 9) ? 3'd1 : 3'd0;
    img[13] = 3'd2;
    img[22] = 3'd3;
    img[24] = 3'd4;
    img[25] = 3'd4;
    img[34] = 3'd4;
    img[35] = 3'd4;
  endtask

  task automatic drive_px(input logic hs, input logic vs, input logic [7:0] rgb);
    bus.hsync  = hs;
    bus.vsync  = vs;
    {bus.vga_r, bus.vga_g, bus.vga_b} = rgb;
    bus.pix_ce = 1'b1;
    @(posedge clk); #1;
    bus.pix_ce = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drive_lines(input int y0, input int y1, input int short_y);
    int len;
    for (int y = y0; y < y1; y++) begin
      len = (y == short_y) ? H_TOTAL - 1 : H_TOTAL;
      for (int x = 0; x < len; x++)
        drive_px(x >= HS_W, y >= VS_W, pix_rgb(x - PIX_DLY, y));
    end
  endtask

  task automatic push_frame();
    frm_t f;
    cnt_m = (cnt_m + 1) & 16'hFFFF;
    if (lock_m < LOCK_FRM) lock_m++;
    f.cnt  = 16'(cnt_m);
    f.lock = (lock_m == LOCK_FRM);
    f.img  = pack_img();
    fq.push_back(f);
  endtask

  task automatic push_rd(input int col, input int row, input logic [2:0] code);
    rd_t r;
    r.col  = 4'(col);
    r.row  = 3'(row);
    r.code = code;
    rq.push_back(r);
  endtask

  task automatic drain_reads();
    for (int k = 0; k < 400 && rq.size() > 0; k++) @(posedge clk);
    #1;
    check("read queue drained", rq.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " locked"},     locked,     0);
    check({tag, " sync_err"},   sync_err,   0);
    check({tag, " color_err"},  color_err,  0);
    check({tag, " frame_cnt"},  frame_cnt,  0);
  endtask

  // Frame-completion monitor: pops the expected frame and queues a full readback.
  initial begin
    frm_t f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sync_err) sync_cnt++;
        if (frame_done) begin
          done_cnt++;
          if (fq.size() == 0) begin
            check("frame_done unexpected", frame_done, 0);
          end else begin
            f = fq.pop_front();
            check("frame_cnt", frame_cnt, f.cnt);
            check("locked at done", locked, f.lock);
            check("color_err at done", color_err, 0);
            for (int i = 0; i < 80; i++) push_rd(i % 10, i / 10, f.img[i*3 +: 3]);
          end
        end
      end
    end
  end

  // Read port driver: one queued read at a time, compared one clock later.
  initial begin
    rd_t r;
    bus.rd_col = '0;
    bus.rd_row = '0;
    forever begin
      @(negedge clk);
      if (rq.size() > 0) begin
        r = rq.pop_front();
        bus.rd_col = r.col;
        bus.rd_row = r.row;
        @(negedge clk);
        check($sformatf("rd c%0d r%0d", r.col, r.row), bus.rd_code, r.code);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus.pix_ce = 1'b0;
    bus.hsync  = 1'b1;
    bus.vsync  = 1'b1;
    {bus.vga_r, bus.vga_g, bus.vga_b} = 8'h00;
    set_board0();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with syncs high: nothing captured, all tiles read as 7.
    for (int i = 0; i < 20; i++) drive_px(1'b1, 1'b1, 8'h00);
    check_idle_outputs("reset");
    for (int i = 0; i < 80; i++) push_rd(i % 10, i / 10, 3'd7);
    push_rd(12, 0, 3'd7);
    push_rd(15, 7, 3'd7);
    drain_reads();

    // Two clean frames of the initial board.
    drive_lines(0, V_TOTAL, -1);
    push_frame();
    drive_lines(0, V_TOTAL, -1);
    push_frame();

    // Frame with one short line: error, unlock, previous board stays readable.
    drive_lines(0, V_TOTAL, 8);
    lock_m = 0;
    check("sync_err after short line", sync_cnt, 1);
    check("locked after short line", locked, 0);
    push_rd(2, 2, 3'd3);
    push_rd(0, 0, 3'd1);

    // Frame one line short: error at the next vsync, capture continues.
    drive_lines(0, V_TOTAL - 1, -1);
    lock_m = 0;

    // White over tile col5,row3.
    img[35] = 3'd7;
    drive_lines(0, V_TOTAL, -1);
    check("sync_err after short frame", sync_cnt, 2);
    check("color_err set", color_err, 1);
    push_frame();

    // Board change during the next frame; mid-frame reads see the old board.
    img[35] = 3'd4;
    img[31] = 3'd3;
    drive_lines(0, 10, -1);
    push_rd(1, 3, 3'd0);
    push_rd(5, 3, 3'd7);
    drive_lines(10, V_TOTAL, -1);
    push_frame();

    // Reset part-way through a frame.
    set_board0();
    drive_lines(0, 10, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_idle_outputs("mid-frame reset");
    rst    = 1'b0;
    cnt_m  = 0;
    lock_m = 0;
    for (int i = 0; i < 80; i++) push_rd(i % 10, i / 10, 3'd7);
    drive_lines(10, V_TOTAL, -1);
    check("no frame_done after reset", done_cnt, 4);

    // Recapture after a fresh vsync, then start one more frame to close it.
    drive_lines(0, V_TOTAL, -1);
    push_frame();
    drive_lines(0, 4, -1);
    drain_reads();

    check("frames pending", fq.size(), 0);
    check("frame_done total", done_cnt, 5);
    check("sync_err total", sync_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
